noc_local_inport: RTL and testbench

//  Router-side local input port: accepts flits driven by the PE (o_valid_to_router/o_data_to_router),

---
 rtl/noc_pkg.sv | 52 +++++
 rtl/noc_flit_fifo.sv | 53 +++++
 rtl/noc_local_inport.sv | 111 +++++++++++
 tb/tb_noc_local_inport.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// noc_pkg: shared definitions for the local input port of the 2x2 mesh router.
//   - flit_w()/dest_lsb()/src_lsb(): flit width and field offsets from DATA_WIDTH/ADDR_WIDTH.
//     Flit layout, MSB first: {src, dest, payload}.
//   - PORT_* : bit index of each crossbar output in the one-hot route vector.
//   - out_state_e : output stage states.
//   - xy_route(): dimension-ordered (X first, then Y) route for a destination address.
package noc_pkg;

   localparam int unsigned PORT_EAST  = 0;
   localparam int unsigned PORT_WEST  = 1;
   localparam int unsigned PORT_NORTH = 2;
   localparam int unsigned PORT_SOUTH = 3;
   localparam int unsigned PORT_LOCAL = 4;
   localparam int unsigned NUM_PORTS  = 5;

   typedef enum logic {
      StEmpty,
      StHold
   } out_state_e;

   function automatic int unsigned flit_w(input int unsigned dw, input int unsigned aw);
      return dw + 2 * aw;
   endfunction

   function automatic int unsigned dest_lsb(input int unsigned dw, input int unsigned aw);
      return dw + 0 * aw;
   endfunction

   function automatic int unsigned src_lsb(input int unsigned dw, input int unsigned aw);
      return dw + aw;
   endfunction

   // Address bit 0 is X, bit 1 is Y; X is resolved first.
   function automatic logic [NUM_PORTS-1:0] xy_route(input logic [1:0] dest,
                                                     input logic [1:0] id);
      logic [NUM_PORTS-1:0] port;
      port = '0;
      if (dest[0] > id[0]) begin
         port[PORT_EAST] = 1'b1;
      end else if (dest[0] < id[0]) begin
         port[PORT_WEST] = 1'b1;
      end else if (dest[1] > id[1]) begin
         port[PORT_SOUTH] = 1'b1;
      end else if (dest[1] < id[1]) begin
         port[PORT_NORTH] = 1'b1;
      end else begin
         port[PORT_LOCAL] = 1'b1;
      end
      return port;
   endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// noc_flit_fifo: flit storage for the local input port.
//   clk_i, rst_ni       : clock, asynchronous active-low reset
//   push_i, wdata_i     : write a flit (caller guarantees !full_o)
//   pop_i, rdata_o      : rdata_o is the head flit; pop_i advances it (caller guarantees !empty_o)
//   full_o, empty_o     : derived from the wrap-bit pointers
//   count_o             : occupancy, present only when NOC_INPORT_STATS_EN is defined
module noc_flit_fifo #(
   parameter int unsigned Width = 20,
   parameter int unsigned Depth = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
`ifdef NOC_INPORT_STATS_EN
   output logic [$clog2(Depth):0] count_o,
`endif
   input  logic             push_i,
   input  logic [Width-1:0] wdata_i,
   input  logic             pop_i,
   output logic [Width-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned IW = $clog2(Depth);
   localparam int unsigned PW = IW + 1;

   logic [Width-1:0] mem_q [Depth];
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;

   // Extra MSB on each pointer distinguishes full from empty when the indices match.
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) && (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]);
   assign rdata_o = mem_q[rd_ptr_q[IW-1:0]];

`ifdef NOC_INPORT_STATS_EN
   assign count_o = wr_ptr_q - rd_ptr_q;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_ptr_q[IW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/noc_local_inport.sv
// noc_local_inport: router-side local input port. Flits from the PE are buffered in a FIFO,
// the head flit is routed XY and held in an output register offered to the crossbar.
// The PE cannot be stalled, so a flit arriving while the FIFO is full is dropped.
//   clk, rst (async, active-low)
//   i_valid, i_data         : flit from the PE, {src, dest, payload}
//   o_valid, o_data, o_port : head flit toward crossbar, one-hot {LOCAL,SOUTH,NORTH,WEST,EAST}
//   i_ready                 : crossbar accepts the head flit
//   o_full, o_empty         : FIFO state (output register not included)
//   o_drop_cnt, o_hiwater   : saturating drop count and peak FIFO occupancy
// Build option: NOC_INPORT_STATS_EN enables the stats registers; otherwise both stats read 0.
module noc_local_inport
   import noc_pkg::*;
#(
   parameter int unsigned           DATA_WIDTH = 16,
   parameter int unsigned           ADDR_WIDTH = 2,
   parameter int unsigned           DEPTH      = 4,
   parameter logic [ADDR_WIDTH-1:0] ROUTER_ID  = '0
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      i_valid,
   input  logic [flit_w(DATA_WIDTH, ADDR_WIDTH)-1:0] i_data,
   output logic                                      o_valid,
   output logic [flit_w(DATA_WIDTH, ADDR_WIDTH)-1:0] o_data,
   output logic [4:0]                                o_port,
   input  logic                                      i_ready,
   output logic                                      o_full,
   output logic                                      o_empty,
   output logic [7:0]                                o_drop_cnt,
   output logic [$clog2(DEPTH):0]                    o_hiwater
);

   localparam int unsigned FW = flit_w(DATA_WIDTH, ADDR_WIDTH);
   localparam int unsigned DL = dest_lsb(DATA_WIDTH, ADDR_WIDTH);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic          fifo_full, fifo_empty, push, load;
   logic [FW-1:0] fifo_head;

   out_state_e     state_q;
   logic [FW-1:0]  data_q;
   logic [4:0]     port_q;

   // A full FIFO refuses the write even if the output stage pops in the same cycle.
   assign push = i_valid && !fifo_full;
   assign load = !fifo_empty && ((state_q == StEmpty) || i_ready);

`ifdef NOC_INPORT_STATS_EN
   logic [CW-1:0] fifo_count;
`endif

   noc_flit_fifo #(
      .Width (FW),
      .Depth (DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_ni  (rst),
`ifdef NOC_INPORT_STATS_EN
      .count_o (fifo_count),
`endif
      .push_i  (push),
      .wdata_i (i_data),
      .pop_i   (load),
      .rdata_o (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Output stage: a load both consumes a pending handshake and refills the register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StEmpty;
         data_q  <= '0;
         port_q  <= '0;
      end else if (load) begin
         state_q <= StHold;
         data_q  <= fifo_head;
         port_q  <= xy_route(fifo_head[DL +: 2], ROUTER_ID[1:0]);
      end else if ((state_q == StHold) && i_ready) begin
         state_q <= StEmpty;
      end
   end

   assign o_valid = (state_q == StHold);
   assign o_data  = data_q;
   assign o_port  = port_q;
   assign o_full  = fifo_full;
   assign o_empty = fifo_empty;

`ifdef NOC_INPORT_STATS_EN
   logic [7:0]    drop_cnt_q;
   logic [CW-1:0] hiwater_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         drop_cnt_q <= '0;
         hiwater_q  <= '0;
      end else begin
         if (i_valid && fifo_full && (drop_cnt_q != 8'hff)) drop_cnt_q <= drop_cnt_q + 8'd1;
         if (fifo_count > hiwater_q) hiwater_q <= fifo_count;
      end
   end

   assign o_drop_cnt = drop_cnt_q;
   assign o_hiwater  = hiwater_q;
`else
   assign o_drop_cnt = '0;
   assign o_hiwater  = '0;
`endif

endmodule

// File: tb/tb_noc_local_inport.sv
module tb_noc_local_inport;

   logic        clk, rst, i_valid, i_ready;
   logic [19:0] i_data;

   logic        o_valid0, o_full0, o_empty0, o_valid3, o_full3, o_empty3;
   logic [19:0] o_data0, o_data3;
   logic [4:0]  o_port0, o_port3;
   logic [7:0]  o_drop_cnt0, o_drop_cnt3;
   logic [2:0]  o_hiwater0, o_hiwater3;

   int total = 0;
   int bad   = 0;

`ifdef NOC_INPORT_STATS_EN
   localparam logic [7:0] EXP_DROP = 8'd1;
   localparam logic [2:0] EXP_HI   = 3'd4;
`else
   localparam logic [7:0] EXP_DROP = 8'd0;
   localparam logic [2:0] EXP_HI   = 3'd0;
`endif

   noc_local_inport #(
      .DATA_WIDTH (16),
      .ADDR_WIDTH (2),
      .DEPTH      (4),
      .ROUTER_ID  (2'd0)
   ) dut0 (
      .clk        (clk),
      .rst        (rst),
      .i_valid    (i_valid),
      .i_data     (i_data),
      .o_valid    (o_valid0),
      .o_data     (o_data0),
      .o_port     (o_port0),
      .i_ready    (i_ready),
      .o_full     (o_full0),
      .o_empty    (o_empty0),
      .o_drop_cnt (o_drop_cnt0),
      .o_hiwater  (o_hiwater0)
   );

   noc_local_inport #(
      .DATA_WIDTH (16),
      .ADDR_WIDTH (2),
      .DEPTH      (4),
      .ROUTER_ID  (2'd3)
   ) dut3 (
      .clk        (clk),
      .rst        (rst),
      .i_valid    (i_valid),
      .i_data     (i_data),
      .o_valid    (o_valid3),
      .o_data     (o_data3),
      .o_port     (o_port3),
      .i_ready    (i_ready),
      .o_full     (o_full3),
      .o_empty    (o_empty3),
      .o_drop_cnt (o_drop_cnt3),
      .o_hiwater  (o_hiwater3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_one(input logic [19:0] d);
      i_valid = 1'b1;
      i_data  = d;
      tick();
      i_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      i_valid = 1'b0;
      i_ready = 1'b0;
      i_data  = '0;
      #1 rst = 1'b0;
      #1;
      total++;
      if (o_valid0 !== 1'b0 || o_empty0 !== 1'b1 || o_port0 !== 5'b0 || o_full0 !== 1'b0) begin
         bad++;
         $display("FAIL reset_outputs: valid=%b empty=%b port=%b full=%b want 0 1 00000 0",
                  o_valid0, o_empty0, o_port0, o_full0);
      end
      total++;
      if (o_data0 !== 20'h0 || o_drop_cnt0 !== 8'd0 || o_hiwater0 !== 3'd0 || o_empty3 !== 1'b1) begin
         bad++;
         $display("FAIL reset_data_stats: data=%h drop=%0d hi=%0d empty3=%b want 0 0 0 1",
                  o_data0, o_drop_cnt0, o_hiwater0, o_empty3);
      end
      tick();
      tick();
      rst = 1'b1;
      tick();
   endtask

   task automatic test_single();
      i_ready = 1'b1;
      push_one(20'h65A5A);
      total++;
      if (o_valid0 !== 1'b0 || o_empty0 !== 1'b0) begin
         bad++;
         $display("FAIL single_latency: valid=%b empty=%b want 0 0", o_valid0, o_empty0);
      end
      tick();
      total++;
      if (o_valid0 !== 1'b1 || o_data0 !== 20'h65A5A || o_port0 !== 5'b01000) begin
         bad++;
         $display("FAIL single_out: valid=%b data=%h port=%b want 1 65a5a 01000",
                  o_valid0, o_data0, o_port0);
      end
      tick();
      total++;
      if (o_valid0 !== 1'b0) begin
         bad++;
         $display("FAIL single_drain: valid=%b want 0", o_valid0);
      end
   endtask

   task automatic test_route();
      logic [19:0] vd [4];
      logic [4:0]  e0 [4];
      logic [4:0]  e3 [4];
      vd = '{20'h40000, 20'h5A5A5, 20'h6A5A5, 20'h7A5A5};
      e0 = '{5'b10000, 5'b00001, 5'b01000, 5'b00001};
      e3 = '{5'b00010, 5'b00100, 5'b00010, 5'b10000};
      i_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         push_one(vd[i]);
         tick();
         total++;
         if (o_valid0 !== 1'b1 || o_valid3 !== 1'b1 || o_data0 !== vd[i] || o_port0 !== e0[i]
             || o_port3 !== e3[i]) begin
            bad++;
            $display("FAIL route_%0d: v0=%b v3=%b data=%h port0=%b port3=%b want 1 1 %h %b %b",
                     i, o_valid0, o_valid3, o_data0, o_port0, o_port3, vd[i], e0[i], e3[i]);
         end
         tick();
      end
   endtask

   task automatic test_overflow();
      i_ready = 1'b0;
      for (int n = 1; n <= 6; n++) begin
         i_valid = 1'b1;
         i_data  = 20'h60000 + 20'(n);
         tick();
      end
      i_valid = 1'b0;
      total++;
      if (o_full0 !== 1'b1 || o_valid0 !== 1'b1 || o_data0 !== 20'h60001 || o_full3 !== 1'b1) begin
         bad++;
         $display("FAIL overflow_full: full=%b valid=%b data=%h full3=%b want 1 1 60001 1",
                  o_full0, o_valid0, o_data0, o_full3);
      end
      total++;
      if (o_drop_cnt0 !== EXP_DROP || o_hiwater0 !== EXP_HI || o_drop_cnt3 !== EXP_DROP
          || o_hiwater3 !== EXP_HI) begin
         bad++;
         $display("FAIL overflow_stats: drop=%0d hi=%0d drop3=%0d hi3=%0d want %0d %0d",
                  o_drop_cnt0, o_hiwater0, o_drop_cnt3, o_hiwater3, EXP_DROP, EXP_HI);
      end
      i_ready = 1'b1;
      for (int n = 2; n <= 5; n++) begin
         tick();
         total++;
         if (o_valid0 !== 1'b1 || o_data0 !== 20'h60000 + 20'(n) || o_data3 !== o_data0) begin
            bad++;
            $display("FAIL overflow_order_%0d: valid=%b data=%h data3=%h want 1 %h",
                     n, o_valid0, o_data0, o_data3, 20'h60000 + 20'(n));
         end
         if (n == 2) begin
            total++;
            if (o_full0 !== 1'b0) begin
               bad++;
               $display("FAIL overflow_unfull: full=%b want 0", o_full0);
            end
         end
      end
      tick();
      total++;
      if (o_valid0 !== 1'b0 || o_empty0 !== 1'b1) begin
         bad++;
         $display("FAIL overflow_drain: valid=%b empty=%b want 0 1", o_valid0, o_empty0);
      end
   endtask

   task automatic test_backpressure();
      i_ready = 1'b0;
      push_one(20'h6BEEF);
      tick();
      for (int c = 0; c < 10; c++) begin
         tick();
         total++;
         if (o_valid0 !== 1'b1 || o_data0 !== 20'h6BEEF || o_port0 !== 5'b01000) begin
            bad++;
            $display("FAIL hold_%0d: valid=%b data=%h port=%b want 1 6beef 01000",
                     c, o_valid0, o_data0, o_port0);
         end
      end
      push_one(20'h61111);
      total++;
      if (o_empty0 !== 1'b0 || o_data0 !== 20'h6BEEF) begin
         bad++;
         $display("FAIL hold_push: empty=%b data=%h want 0 6beef", o_empty0, o_data0);
      end
      i_ready = 1'b1;
      push_one(20'h62222);
      total++;
      if (o_data0 !== 20'h61111 || o_empty0 !== 1'b0 || o_full0 !== 1'b0) begin
         bad++;
         $display("FAIL push_pop: data=%h empty=%b full=%b want 61111 0 0",
                  o_data0, o_empty0, o_full0);
      end
      tick();
      total++;
      if (o_valid0 !== 1'b1 || o_data0 !== 20'h62222 || o_empty0 !== 1'b1) begin
         bad++;
         $display("FAIL push_pop_next: valid=%b data=%h empty=%b want 1 62222 1",
                  o_valid0, o_data0, o_empty0);
      end
      tick();
      total++;
      if (o_valid0 !== 1'b0) begin
         bad++;
         $display("FAIL push_pop_drain: valid=%b want 0", o_valid0);
      end
   endtask

   task automatic test_reset_mid();
      i_ready = 1'b0;
      push_one(20'h6AAAA);
      push_one(20'h6BBBB);
      total++;
      if (o_valid0 !== 1'b1 || o_empty0 !== 1'b0) begin
         bad++;
         $display("FAIL mid_setup: valid=%b empty=%b want 1 0", o_valid0, o_empty0);
      end
      #3 rst = 1'b0;
      #1;
      total++;
      if (o_valid0 !== 1'b0 || o_empty0 !== 1'b1 || o_port0 !== 5'b0 || o_data0 !== 20'h0
          || o_drop_cnt0 !== 8'd0 || o_hiwater0 !== 3'd0) begin
         bad++;
         $display("FAIL mid_reset: valid=%b empty=%b port=%b data=%h drop=%0d hi=%0d want 0 1 0 0 0 0",
                  o_valid0, o_empty0, o_port0, o_data0, o_drop_cnt0, o_hiwater0);
      end
      #2 rst = 1'b1;
      i_ready = 1'b1;
      tick();
      tick();
      total++;
      if (o_valid0 !== 1'b0 || o_empty0 !== 1'b1) begin
         bad++;
         $display("FAIL mid_discard: valid=%b empty=%b want 0 1", o_valid0, o_empty0);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_route();
      test_overflow();
      test_backpressure();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
